// File: rtl/uarch_pkg.sv
// uarch_pkg: shared fetch-stage widths, constants and packet types
package uarch_pkg;
  localparam int CPU_ADDR_BITS      = 32;
  localparam int CPU_INST_BITS      = 32;
  localparam int FETCH_WIDTH        = 2;
  localparam int FETCH_BYTES        = FETCH_WIDTH * 4;
  localparam int MAX_FETCH_INFLIGHT = 2;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0]             pc;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] data;
  } fetch_pkt_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO with active-low sync reset, synchronous clear and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  assign dout  = r_mem[r_rd];
  assign count = r_cnt;
  // storage is written on push only and needs no reset
  always_ff @(posedge clk)
    if (push) r_mem[r_wr] <= din;
  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rst || clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: credit-based fetch sequencer pairing I-Cache responses with PCs; FETCH_PERF_CNT_EN adds perf counters
module fetch_ctrl
  import uarch_pkg::*;
#(
  parameter logic [CPU_ADDR_BITS-1:0] RESET_PC     = '0,
  parameter int                       MAX_INFLIGHT = MAX_FETCH_INFLIGHT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 redirect_val,
  input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
  output logic                                 icache_req_val,
  input  logic                                 icache_req_rdy,
  output logic [CPU_ADDR_BITS-1:0]             icache_req_addr,
  input  logic                                 icache_resp_val,
  input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_resp_data,
  output logic [CPU_ADDR_BITS-1:0]             buf_pc,
  output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] buf_data,
  output logic                                 buf_val,
  input  logic                                 buf_rdy,
  output logic                                 buf_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_credit_stall,
  output logic [31:0]                          perf_dropped,
  output logic [31:0]                          perf_redirects
`endif
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  logic [CPU_ADDR_BITS-1:0] r_fetch_pc, w_pc_head;
  logic [CW-1:0]            r_credits, r_drop_cnt, w_credits_nxt, w_drop_nxt, w_pc_cnt, w_rs_cnt;
  fetch_state_e             r_state;
  fetch_pkt_t               w_rs_head;
  logic                     w_issue, w_resp, w_drop, w_keep, w_fwd, w_show;
  assign icache_req_val  = rst && r_credits != '0 && !redirect_val;
  assign icache_req_addr = r_fetch_pc;
  assign w_issue         = icache_req_val && icache_req_rdy;
  assign w_resp          = rst && icache_resp_val;
  assign w_drop          = w_resp && (r_state == DRAIN || redirect_val);
  assign w_keep          = w_resp && !w_drop;
  assign w_show          = rst && w_rs_cnt != '0;
  assign buf_val         = w_show && !redirect_val;
  assign w_fwd           = buf_val && buf_rdy;
  assign buf_pc          = w_show ? w_rs_head.pc : '0;
  assign buf_data        = w_show ? w_rs_head.data : '0;
  assign buf_flush       = rst && redirect_val;
  sync_fifo #(.WIDTH(CPU_ADDR_BITS), .DEPTH(MAX_INFLIGHT)) u_pc_fifo (
    .clk(clk), .rst(rst), .clr(1'b0), .push(w_issue), .din(r_fetch_pc),
    .pop(w_resp), .dout(w_pc_head), .count(w_pc_cnt)
  );
  sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(MAX_INFLIGHT)) u_resp_fifo (
    .clk(clk), .rst(rst), .clr(redirect_val), .push(w_keep), .din({w_pc_head, icache_resp_data}),
    .pop(w_fwd), .dout(w_rs_head), .count(w_rs_cnt)
  );
  // a redirect drops everything still in flight (minus a response accepted this cycle) and frees the rest
  always_comb begin
    w_drop_nxt    = redirect_val ? w_pc_cnt - CW'(w_resp) : r_drop_cnt - CW'(w_drop);
    w_credits_nxt = redirect_val ? CW'(MAX_INFLIGHT) - w_drop_nxt
                                 : r_credits - CW'(w_issue) + CW'(w_drop) + CW'(w_fwd);
  end
  // fetch PC, credits and RUN/DRAIN sequencing
  always_ff @(posedge clk)
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_credits  <= CW'(MAX_INFLIGHT);
      r_drop_cnt <= '0;
      r_state    <= RUN;
    end else begin
      r_fetch_pc <= redirect_val ? redirect_pc : w_issue ? r_fetch_pc + CPU_ADDR_BITS'(FETCH_BYTES) : r_fetch_pc;
      r_credits  <= w_credits_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_state    <= w_drop_nxt != '0 ? DRAIN : RUN;
    end
  a_resp_has_pc: assert property (@(posedge clk) disable iff (!rst) icache_resp_val |-> w_pc_cnt != '0);
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_drop, r_perf_redir;
  assign perf_credit_stall = r_perf_stall;
  assign perf_dropped      = r_perf_drop;
  assign perf_redirects    = r_perf_redir;
  // saturating event counters
  always_ff @(posedge clk)
    if (!rst) begin
      r_perf_stall <= '0;
      r_perf_drop  <= '0;
      r_perf_redir <= '0;
    end else begin
      r_perf_stall <= r_perf_stall + 32'(r_credits == '0 && !redirect_val && r_perf_stall != '1);
      r_perf_drop  <= r_perf_drop + 32'(w_drop && r_perf_drop != '1);
      r_perf_redir <= r_perf_redir + 32'(redirect_val && r_perf_redir != '1);
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl with an in-order I-Cache model
module tb_fetch_ctrl;
  import uarch_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_val = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_req_val;
  logic        icache_req_rdy = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_resp_val = 1'b0;
  logic [63:0] icache_resp_data = '0;
  logic [31:0] buf_pc;
  logic [63:0] buf_data;
  logic        buf_val;
  logic        buf_rdy = 1'b0;
  logic        buf_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_credit_stall, perf_dropped, perf_redirects;
`endif
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_flush = 0;
  int          n_rst_act = 0;
  logic        hold = 1'b0;
  logic [31:0] cq[$];
  logic [31:0] exp_q[$];
  logic [31:0] iss[$];
  logic [31:0] fwd[$];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .icache_req_val(icache_req_val), .icache_req_rdy(icache_req_rdy), .icache_req_addr(icache_req_addr),
    .icache_resp_val(icache_resp_val), .icache_resp_data(icache_resp_data),
    .buf_pc(buf_pc), .buf_data(buf_data), .buf_val(buf_val), .buf_rdy(buf_rdy), .buf_flush(buf_flush)
`ifdef FETCH_PERF_CNT_EN
    , .perf_credit_stall(perf_credit_stall), .perf_dropped(perf_dropped), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pkt(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_5A5A};
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle starting at a negedge: drive the cache response, observe handshakes, advance to next negedge
  task automatic step();
    logic [31:0] a;
    logic [31:0] e;
    icache_resp_val  = 1'b0;
    icache_resp_data = '0;
    if (!hold && cq.size() > 0) begin
      a = cq.pop_front();
      icache_resp_val  = 1'b1;
      icache_resp_data = pkt(a);
    end
    #1;
    if (buf_flush) n_flush++;
    if (!rst && (buf_val || icache_req_val || buf_flush)) n_rst_act++;
    if (redirect_val || !rst) exp_q.delete();
    if (icache_req_val && icache_req_rdy) begin
      cq.push_back(icache_req_addr);
      exp_q.push_back(icache_req_addr);
      iss.push_back(icache_req_addr);
    end
    if (buf_val && buf_rdy) begin
      fwd.push_back(buf_pc);
      check("sb_nonempty", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", 96'(buf_pc), 96'(e));
        check("sb_data", 96'(buf_data), 96'(pkt(e)));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_val = 1'b1;
    redirect_pc  = pc;
    step();
    redirect_val = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_val", 96'(icache_req_val), 96'd0);
    check("rst_buf_val", 96'(buf_val), 96'd0);
    check("rst_flush", 96'(buf_flush), 96'd0);
    check("rst_buf_pc", 96'(buf_pc), 96'd0);
    check("rst_buf_data", 96'(buf_data), 96'd0);
    @(negedge clk);
    // streaming fetch from RESET_PC
    rst = 1'b1;
    icache_req_rdy = 1'b1;
    buf_rdy = 1'b1;
    run(8);
    check("t1_n_issue", 96'(iss.size() >= 3), 96'd1);
    check("t1_addr0", 96'(iss[0]), 96'h0);
    check("t1_addr1", 96'(iss[1]), 96'h8);
    check("t1_addr2", 96'(iss[2]), 96'h10);
    icache_req_rdy = 1'b0;
    run(4);
    check("t1_drained", 96'(exp_q.size()), 96'd0);
    // buffer backpressure: only MAX_INFLIGHT requests issue
    redirect(32'h0);
    iss.delete();
    fwd.delete();
    buf_rdy = 1'b0;
    icache_req_rdy = 1'b1;
    run(10);
    check("t2_n_issue", 96'(iss.size()), 96'd2);
    check("t2_req_val", 96'(icache_req_val), 96'd0);
    check("t2_buf_val", 96'(buf_val), 96'd1);
    check("t2_head_pc", 96'(buf_pc), 96'h0);
    icache_req_rdy = 1'b0;
    buf_rdy = 1'b1;
    run(3);
    check("t2_n_fwd", 96'(fwd.size()), 96'd2);
    check("t2_fwd0", 96'(fwd[0]), 96'h0);
    check("t2_fwd1", 96'(fwd[1]), 96'h8);
    // redirect with two requests in flight
    iss.delete();
    hold = 1'b1;
    icache_req_rdy = 1'b1;
    run(2);
    n_flush = 0;
    redirect(32'h100);
    check("t3_no_issue", 96'(iss.size()), 96'd2);
    hold = 1'b0;
    fwd.delete();
    run(6);
    check("t3_flush_1cyc", 96'(n_flush), 96'd1);
    check("t3_n_fwd", 96'(fwd.size() >= 1), 96'd1);
    check("t3_fwd0", 96'(fwd[0]), 96'h100);
`ifdef FETCH_PERF_CNT_EN
    check("t3_perf_drop", 96'(perf_dropped), 96'd2);
    check("t3_perf_redir", 96'(perf_redirects), 96'd2);
`endif
    // redirect coinciding with a response: only one request left to drop
    icache_req_rdy = 1'b0;
    run(4);
    hold = 1'b1;
    icache_req_rdy = 1'b1;
    run(2);
    hold = 1'b0;
    redirect(32'h200);
    fwd.delete();
    #1;
    check("t4_req_val", 96'(icache_req_val), 96'd1);
    check("t4_req_addr", 96'(icache_req_addr), 96'h200);
    run(5);
    check("t4_n_fwd", 96'(fwd.size() >= 1), 96'd1);
    check("t4_fwd0", 96'(fwd[0]), 96'h200);
    // address wrap
    icache_req_rdy = 1'b0;
    run(4);
    redirect(32'hFFFF_FFF8);
    iss.delete();
    icache_req_rdy = 1'b1;
    run(4);
    check("t5_n_issue", 96'(iss.size() >= 2), 96'd1);
    check("t5_addr0", 96'(iss[0]), 96'hFFFF_FFF8);
    check("t5_wrap", 96'(iss[1]), 96'h0);
    // reset with requests in flight, late responses arriving during reset
    icache_req_rdy = 1'b0;
    run(4);
    hold = 1'b1;
    icache_req_rdy = 1'b1;
    run(2);
    rst = 1'b0;
    hold = 1'b0;
    n_rst_act = 0;
    run(4);
    check("t6_quiet_in_rst", 96'(n_rst_act), 96'd0);
    check("t6_cache_empty", 96'(cq.size()), 96'd0);
    rst = 1'b1;
    iss.delete();
    fwd.delete();
    run(5);
    check("t6_n_issue", 96'(iss.size() >= 1), 96'd1);
    check("t6_restart", 96'(iss[0]), 96'h0);
    check("t6_n_fwd", 96'(fwd.size() >= 1), 96'd1);
    check("t6_fwd0", 96'(fwd[0]), 96'h0);
    icache_req_rdy = 1'b0;
    run(4);
    check("final_drained", 96'(exp_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
